// File: rtl/lab_pkg.sv
// Request codes and output FSM states shared with the downstream request FSM.
// Constants only, no logic; no flow control.
package lab_pkg;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_S1   = 2'b01;
    localparam logic [1:0] REQ_S2   = 2'b10;

    typedef enum logic {
        READY = 1'b0,
        GAP   = 1'b1
    } out_state_t;

endpackage

// File: rtl/btn_req_encoder_if.sv
// Raw button levels in, registered request code out.
// No latency or backpressure at this level; the encoder always accepts button levels.
interface btn_req_encoder_if;

    logic [1:0] btn;
    logic [1:0] a;

    modport master (output btn, input a);
    modport slave  (input btn, output a);

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, then a debounced level that flips after DEBOUNCE_CYCLES stable samples.
// Level changes DEBOUNCE_CYCLES+1 edges after the input is first sampled; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Any sample agreeing with the debounced level restarts the stability count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_req_encoder.sv
// Debounced button presses become one-cycle request codes separated by at least one idle cycle.
// Press-to-code is DEBOUNCE_CYCLES+3 edges; presses arriving while a code is outstanding are held as pending.
module btn_req_encoder
    import lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    btn_req_encoder_if.slave   bus
);

    logic [1:0] level;
    logic [1:0] level_d;
    logic [1:0] rise;
    logic [1:0] pend;
    logic [1:0] pend_clr;
    logic [1:0] a_q;
    logic [1:0] a_nxt;
    out_state_t state;
    out_state_t state_nxt;

    for (genvar i = 0; i < 2; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .btn   (bus.btn[i]),
            .level (level[i])
        );
    end

    assign rise = level & ~level_d;

    // Button 0 has priority; GAP forces an idle cycle after every code.
    always_comb begin
        state_nxt = state;
        a_nxt     = REQ_NONE;
        pend_clr  = 2'b00;
        case (state)
            READY: begin
                if (pend[0]) begin
                    a_nxt     = REQ_S1;
                    pend_clr  = 2'b01;
                    state_nxt = GAP;
                end else if (pend[1]) begin
                    a_nxt     = REQ_S2;
                    pend_clr  = 2'b10;
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = READY;
            default: state_nxt = READY;
        endcase
    end

    // A new rise wins over a same-edge clear, so that press is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_d <= 2'b00;
            pend    <= 2'b00;
            state   <= READY;
            a_q     <= REQ_NONE;
        end else begin
            level_d <= level;
            pend    <= (pend & ~pend_clr) | rise;
            state   <= state_nxt;
            a_q     <= a_nxt;
        end
    end

    assign bus.a = a_q;

endmodule

// File: tb/tb_btn_req_encoder.sv
// Directed checks of btn_req_encoder with DEBOUNCE_CYCLES=4; edge 0 is the first edge sampling the new btn value.
module tb_btn_req_encoder;
    import lab_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;

    btn_req_encoder_if bus ();

    btn_req_encoder #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.btn = 2'b00;
        reset   = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        chk("reset_a", bus.a, REQ_NONE);
        tick();
    endtask

    // The code must never be 2'b11, whatever the test.
    always @(negedge clk) begin
        total++;
        assert (bus.a !== 2'b11) passed++;
        else $error("FAIL never_11: observed %b expected not 11", bus.a);
    end

    initial begin
        bus.btn = 2'b00;
        reset   = 1'b1;
        do_reset();

        // Single press of button 0: one S1 pulse after edge 7.
        bus.btn = 2'b01;
        for (int e = 0; e <= 12; e++) begin
            tick();
            chk($sformatf("single_e%0d", e), bus.a, (e == 7) ? REQ_S1 : REQ_NONE);
        end
        do_reset();

        // Both pressed together: S1 after edge 7, idle after 8, S2 after 9.
        bus.btn = 2'b11;
        for (int e = 0; e <= 13; e++) begin
            tick();
            chk($sformatf("both_e%0d", e), bus.a,
                (e == 7) ? REQ_S1 : (e == 9) ? REQ_S2 : REQ_NONE);
        end
        do_reset();

        // Three-cycle glitch on button 1 never reaches the output.
        bus.btn = 2'b10;
        for (int e = 0; e <= 14; e++) begin
            tick();
            if (e == 2) bus.btn = 2'b00;
            chk($sformatf("glitch_e%0d", e), bus.a, REQ_NONE);
        end
        do_reset();

        // Reset at edge 5 cancels the debounce; held button is a new press from edge 6.
        bus.btn = 2'b01;
        for (int e = 0; e <= 4; e++) begin
            tick();
            chk($sformatf("midrst_pre_e%0d", e), bus.a, REQ_NONE);
        end
        reset = 1'b1;
        tick();
        chk("midrst_at_reset", bus.a, REQ_NONE);
        reset = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            tick();
            chk($sformatf("midrst_post_k%0d", k), bus.a, (k == 7) ? REQ_S1 : REQ_NONE);
        end
        do_reset();

        // Reset while S2 is still pending discards it.
        bus.btn = 2'b11;
        for (int e = 0; e <= 7; e++) begin
            tick();
            chk($sformatf("pendrst_e%0d", e), bus.a, (e == 7) ? REQ_S1 : REQ_NONE);
        end
        bus.btn = 2'b00;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            tick();
            chk($sformatf("pendrst_post_k%0d", k), bus.a, REQ_NONE);
        end
        do_reset();

        // Press, release 10 cycles, press again: two separate S1 pulses.
        bus.btn = 2'b01;
        for (int e = 0; e <= 37; e++) begin
            tick();
            if (e == 14) bus.btn = 2'b00;
            if (e == 24) bus.btn = 2'b01;
            chk($sformatf("repress_e%0d", e), bus.a,
                (e == 7 || e == 32) ? REQ_S1 : REQ_NONE);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/btn_req_encoder.md
BTN_REQ_ENCODER -- requirements
Module: btn_req_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16 (min 2); number of consecutive stable synchronized samples needed to accept a button level change.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 btn  input  2  raw asynchronous push-button levels; btn[0] maps to code 2'b01, btn[1] maps to code 2'b10.
REQ-005 a  output  2  registered request code for the downstream 2-bit request FSM input; 2'b00 none, 2'b01 request S1, 2'b10 request S2.

Function
REQ-006 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-007 Per button, a debounce counter SHALL increment each cycle the synchronized level differs from the debounced level, and clear when they match.
REQ-008 When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level SHALL flip and the counter SHALL clear on that edge.
REQ-009 A 0->1 transition of a debounced level SHALL set that button's pending bit on the next edge; 1->0 transitions SHALL be ignored.
REQ-010 Pending bits SHALL saturate: a new press while pending is already set is coalesced and not counted.
REQ-011 Output FSM states: READY, GAP.
REQ-012 READY: if pend[0], a <= 2'b01, clear pend[0], go GAP; else if pend[1], a <= 2'b10, clear pend[1], go GAP; else a <= 2'b00, stay READY.
REQ-013 GAP: a <= 2'b00 unconditionally, go READY; a non-zero code SHALL therefore last exactly one cycle and be followed by at least one 2'b00 cycle.
REQ-014 a SHALL never equal 2'b11.
REQ-015 Simultaneous presses (both pending set on same edge): 2'b01 emitted first, 2'b10 emitted two cycles later; neither lost.
REQ-016 Pending set and clear on the same edge for the same button: set wins.
REQ-017 Latency: a clean press of an idle button with FSM in READY, held stable, SHALL produce the code in the cycle after the DEBOUNCE_CYCLES+3rd rising edge counted from the edge at which btn is first sampled high.
REQ-018 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no code.
REQ-019 Releasing and re-pressing after debouncing SHALL produce a new code each press.

Reset
REQ-020 On reset: synchronizer flops 0, debounced levels 0, counters 0, pending bits 0, FSM READY, a = 2'b00, all on the next edge.
REQ-021 Reset asserted mid-debounce or with pending bits set SHALL discard them; no code emitted for them after reset release.
REQ-022 A button held high through reset release SHALL be treated as a new press and emit its code after the REQ-017 latency.

Structure
REQ-023 Request code constants (REQ_NONE, REQ_S1, REQ_S2) and the output FSM state enum SHALL live in shared package lab_pkg, also used by the downstream request FSM.
REQ-024 Synchronizer plus debounce counter plus debounced level SHALL be one sub-module, btn_debounce, instantiated once per button.
REQ-025 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); no other arithmetic.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 btn=2'b01 held from edge 0 -> a=2'b01 for exactly one cycle after edge 7, 2'b00 otherwise.
REQ-027 btn=2'b11 both rise at edge 0 -> a=2'b01 after edge 7, 2'b00 after edge 8, 2'b10 after edge 9.
REQ-028 btn[1] high for 3 cycles then low -> a stays 2'b00 throughout.
REQ-029 btn[0] pressed, reset pulsed at edge 5, btn held -> no code before reset; a=2'b01 after the 7th edge counted from reset release.
REQ-030 btn[0] press, release 10 cycles, press again -> two separate 2'b01 pulses, each followed by 2'b00; a never 2'b11 (assertion over all tests).
